hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. Resolves EX operand forwarding, load-use stalls and

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/hazard_perf_counters.sv | 56 +++++
 rtl/hazard_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types, encodings and forwarding helper for the
//                RV32I hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    // MEM is the younger producer, so it must win over WB when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_counters.sv
// ============================================================================
//  Module      : hazard_perf_counters
//  Description : Stall, flush and load-use event counters; wrap at 2^CNT_W
//                and hold while frozen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             load_use_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] load_use_cnt
);

    logic [CNT_W-1:0] stall_cnt_d,    stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d,    flush_cnt_q;
    logic [CNT_W-1:0] load_use_cnt_d, load_use_cnt_q;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        load_use_cnt_d = load_use_cnt_q;
        if (!freeze) begin
            if (stall_inc)    stall_cnt_d    = stall_cnt_q + 1'b1;
            if (flush_inc)    flush_cnt_d    = flush_cnt_q + 1'b1;
            if (load_use_inc) load_use_cnt_d = load_use_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            load_use_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign load_use_cnt = load_use_cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
//  Module      : hazard_controller
//  Description : 5-stage RV32I hazard unit: EX forwarding, load-use stalls,
//                branch flushes and data-memory handshake with timeout.
//                Define HZ_PERF_CNT_EN to build the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemAccessM,
    input  logic             DmemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             DmemReqM,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] LoadUseCnt
);

    import hazard_pkg::*;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    hz_state_t   state_d,    state_q;
    logic [15:0] wait_cnt_d, wait_cnt_q;
    logic        w_lw_stall;
    logic        w_mem_stall;

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign w_lw_stall  = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mem_stall = ((state_q == IDLE) && MemAccessM && !DmemReadyM) ||
                         ((state_q == WAIT) && !DmemReadyM) ||
                         (state_q == ERR);

    // A memory freeze holds every stage, including W; the regfile rewrite is harmless.
    always_comb begin
        StallF = w_lw_stall;
        StallD = w_lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = PCSrcE;
        FlushE = w_lw_stall | PCSrcE;
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end
    end

    assign DmemReqM = ((state_q == IDLE) && MemAccessM) || (state_q == WAIT);
    assign MemErr   = (state_q == ERR);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (MemAccessM && !DmemReadyM)
                    state_d = WAIT;
            end
            WAIT: begin
                if (DmemReadyM) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HZ_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .reset        (reset),
        .freeze       (state_q == ERR),
        .stall_inc    (StallF),
        .flush_inc    ((FlushD | FlushE) && !w_mem_stall),
        .load_use_inc (w_lw_stall && !w_mem_stall),
        .stall_cnt    (StallCnt),
        .flush_cnt    (FlushCnt),
        .load_use_cnt (LoadUseCnt)
    );
`else
    assign StallCnt   = '0;
    assign FlushCnt   = '0;
    assign LoadUseCnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Directed self-checking bench for hazard_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, MemAccessM, DmemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE, DmemReqM, MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt, LoadUseCnt;

    int n_checks = 0;
    int n_fail   = 0;

    wire [8:0] ctl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, DmemReqM, MemErr};

    // ctl = {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,DmemReqM,MemErr}
    localparam logic [8:0] C_CLEAN    = 9'b00000_00_0_0;
    localparam logic [8:0] C_LOADUSE  = 9'b11000_01_0_0;
    localparam logic [8:0] C_BRANCH   = 9'b00000_11_0_0;
    localparam logic [8:0] C_BR_LU    = 9'b11000_11_0_0;
    localparam logic [8:0] C_MEMWAIT  = 9'b11111_00_1_0;
    localparam logic [8:0] C_MEMREQ   = 9'b00000_00_1_0;
    localparam logic [8:0] C_REL_BR   = 9'b00000_11_1_0;
    localparam logic [8:0] C_ERR      = 9'b11111_00_0_1;

    always #5 clk = ~clk;

    hazard_controller #(
        .MEM_TIMEOUT(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE (ResultSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MemAccessM (MemAccessM),
        .DmemReadyM (DmemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .StallW     (StallW),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .DmemReqM   (DmemReqM),
        .MemErr     (MemErr),
        .StallCnt   (StallCnt),
        .FlushCnt   (FlushCnt),
        .LoadUseCnt (LoadUseCnt)
    );

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        MemAccessM = 1'b0; DmemReadyM = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, C_CLEAN);
        end
        n_checks++;
        if ({StallCnt, FlushCnt, LoadUseCnt} !== {3{16'd0}}) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", StallCnt, FlushCnt, LoadUseCnt);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_mem_priority: got A=%b B=%b expected A=10 B=00", ForwardAE, ForwardBE);
        end
        RegWriteM = 1'b0;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_wb: got %b expected 01", ForwardAE);
        end
        RegWriteM = 1'b1; RdW = 5'd3; Rs1E = 5'd9; Rs2E = 5'd3;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_b_wb: got A=%b B=%b expected A=00 B=01", ForwardAE, ForwardBE);
        end
        Rs2E = 5'd5;
        #1;
        n_checks++;
        if (ForwardBE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_b_mem: got %b expected 10", ForwardBE);
        end
        clear_inputs();
        RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_x0_guard: got A=%b B=%b expected 00 00", ForwardAE, ForwardBE);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 5'd0;
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL lw_x0: got %b expected %b", ctl, C_CLEAN);
        end
        RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd2;
        #1;
        n_checks++;
        if (ctl !== C_LOADUSE) begin
            n_fail++;
            $display("FAIL lw_stall: got %b expected %b", ctl, C_LOADUSE);
        end
        tick();
        ResultSrcE = 2'b00; RdE = 5'd0;
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL lw_one_cycle: got %b expected %b", ctl, C_CLEAN);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        PCSrcE = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4;
        #1;
        n_checks++;
        if (ctl !== C_BR_LU) begin
            n_fail++;
            $display("FAIL branch_and_lw: got %b expected %b", ctl, C_BR_LU);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        MemAccessM = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) PCSrcE = 1'b1;
            #1;
            n_checks++;
            if (ctl !== C_MEMWAIT) begin
                n_fail++;
                $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, ctl, C_MEMWAIT);
            end
            tick();
        end
        DmemReadyM = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_REL_BR) begin
            n_fail++;
            $display("FAIL mem_release: got %b expected %b", ctl, C_REL_BR);
        end
        tick();
        PCSrcE = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_MEMREQ) begin
            n_fail++;
            $display("FAIL mem_zero_stall: got %b expected %b", ctl, C_MEMREQ);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL mem_back_idle: got %b expected %b", ctl, C_CLEAN);
        end
    endtask

    task automatic test_counters(input int exp_stall, input int exp_flush, input int exp_lu, input string tag);
        logic [CNT_W-1:0] es, ef, el;
`ifdef HZ_PERF_CNT_EN
        es = CNT_W'(exp_stall); ef = CNT_W'(exp_flush); el = CNT_W'(exp_lu);
`else
        es = '0; ef = '0; el = '0;
        if (exp_stall + exp_flush + exp_lu < 0) es = '1;
`endif
        n_checks++;
        if (StallCnt !== es || FlushCnt !== ef || LoadUseCnt !== el) begin
            n_fail++;
            $display("FAIL counters_%s: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     tag, StallCnt, FlushCnt, LoadUseCnt, es, ef, el);
        end
    endtask

    task automatic test_timeout();
        clear_inputs();
        MemAccessM = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (ctl !== C_MEMWAIT) begin
            n_fail++;
            $display("FAIL timeout_last_wait: got %b expected %b", ctl, C_MEMWAIT);
        end
        tick();
        n_checks++;
        if (ctl !== C_ERR) begin
            n_fail++;
            $display("FAIL timeout_err: got %b expected %b", ctl, C_ERR);
        end
        MemAccessM = 1'b0; DmemReadyM = 1'b1; PCSrcE = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ctl !== C_ERR) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected %b", ctl, C_ERR);
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL err_reset: got %b expected %b", ctl, C_CLEAN);
        end
        MemAccessM = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        MemAccessM = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_CLEAN) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %b expected %b", ctl, C_CLEAN);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        // stalls: 1 load-use + 1 branch/lw + 3 mem; flushes: lu, br, br+lu, release
        test_counters(5, 4, 2, "after_mem");
        test_timeout();
        // 1 IDLE miss + 4 WAIT cycles stall before ERR, then frozen
        test_counters(10, 4, 2, "err_frozen");
        test_reset_mid_wait();
        test_counters(0, 0, 0, "after_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
